// File: rtl/spi_cmd_regfile.sv
// spi_cmd_regfile: command decoder and byte-wide register file behind the PL SPI slave.
// The first byte of a frame is a command (bit7 = read, bits[6:0] = start address).
// The following bytes are write data or read dummies, with an auto-incrementing address.
// Register 0 is a read-only ID byte. Every output comes straight from a flop.
module spi_cmd_regfile #(
  parameter int         NUM_REGS = 16,
  parameter int         ADDR_W   = 4,
  parameter logic [7:0] ID_BYTE  = 8'hA5
) (
  input  logic                  clk100,
  input  logic                  rstn,
  input  logic                  csn_i,
  input  logic [7:0]            rx_byte_i,
  input  logic                  rx_valid_i,
  output logic [7:0]            tx_byte_o,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic [NUM_REGS-1:0]   wr_strobe_o,
  output logic [15:0]           frame_cnt_o,
  output logic [7:0]            err_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_WR   = 3'd2,
    S_RD   = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [ADDR_W-1:0]   w_addr_inc;
  logic [ADDR_W-1:0]   w_cmd_addr;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [7:0]          w_rd_data;
  logic [7:0]          r_tx;
  logic [7:0]          w_tx_nxt;
  logic [7:0]          r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_strobe;
  logic [15:0]         r_frame_cnt;
  logic [7:0]          r_err_cnt;
  logic                r_csn_d;
  logic                w_fall;
  logic                w_rise;
  logic                w_stray;
  logic                w_addr_ok;
  logic                w_wr_en;
  logic                w_err_inc;
  logic                w_frame_inc;

  // The chip-select history flop resets low. A frame only starts after csn_i has been seen
  // high and then low, so a csn_i that is already low when reset releases is not taken as a start.
  assign w_fall     = r_csn_d & ~csn_i;
  assign w_rise     = ~r_csn_d & csn_i;
  assign w_stray    = rx_valid_i & csn_i & r_csn_d;
  assign w_cmd_addr = rx_byte_i[ADDR_W-1:0];
  assign w_addr_ok  = ((rx_byte_i[6:0] >> ADDR_W) == 7'd0);
  assign w_addr_inc = r_addr + ADDR_W'(1);
  assign w_rd_addr  = (r_state == S_CMD) ? w_cmd_addr : w_addr_inc;
  assign w_rd_data  = r_regs[w_rd_addr];

  // Next-state, address, tx byte and event decode for the frame FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_tx_nxt    = r_tx;
    w_wr_en     = 1'b0;
    w_err_inc   = w_stray;
    w_frame_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = ID_BYTE;
        if (w_fall) w_state_nxt = S_CMD;
        else        w_state_nxt = S_IDLE;
      end
      S_CMD: begin
        if (rx_valid_i) begin
          w_addr_nxt = w_cmd_addr;
          if (!w_addr_ok) begin
            w_state_nxt = S_DROP;
            w_err_inc   = 1'b1;
            w_tx_nxt    = ID_BYTE;
          end else if (rx_byte_i[7]) begin
            w_state_nxt = S_RD;
            w_tx_nxt    = w_rd_data;
          end else begin
            w_state_nxt = S_WR;
            w_tx_nxt    = ID_BYTE;
          end
        end else begin
          w_tx_nxt = ID_BYTE;
        end
      end
      S_WR: begin
        w_tx_nxt = ID_BYTE;
        if (rx_valid_i) begin
          w_addr_nxt = w_addr_inc;
          if (r_addr != '0) w_wr_en   = 1'b1;
          else              w_err_inc = 1'b1;
        end else begin
          w_addr_nxt = r_addr;
        end
      end
      S_RD: begin
        if (rx_valid_i) begin
          w_addr_nxt = w_addr_inc;
          w_tx_nxt   = w_rd_data;
        end else begin
          w_addr_nxt = r_addr;
        end
      end
      S_DROP: begin
        w_tx_nxt = ID_BYTE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = ID_BYTE;
      end
    endcase
    // The end of a frame overrides whatever the byte on this cycle did to the state.
    if (w_rise && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_tx_nxt    = ID_BYTE;
      if ((r_state == S_CMD) && !rx_valid_i) w_err_inc   = 1'b1;
      else                                   w_frame_inc = 1'b1;
    end else begin
      w_frame_inc = 1'b0;
    end
  end

  // State, address, tx byte and chip-select history registers.
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_tx    <= ID_BYTE;
      r_csn_d <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_tx    <= w_tx_nxt;
      r_csn_d <= csn_i;
    end
  end

  // Register array and write strobes. Entry 0 holds the ID byte and is never written.
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= (i == 0) ? ID_BYTE : 8'h00;
      r_strobe <= '0;
    end else begin
      r_strobe <= '0;
      if (w_wr_en) begin
        r_regs[r_addr]   <= rx_byte_i;
        r_strobe[r_addr] <= 1'b1;
      end
    end
  end

  // The frame counter wraps. The error counter saturates at 8'hFF.
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 8'd0;
    end else begin
      if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_regs_out
    assign regs_o[8*n +: 8] = r_regs[n];
  end

  assign tx_byte_o   = r_tx;
  assign wr_strobe_o = r_strobe;
  assign frame_cnt_o = r_frame_cnt;
  assign err_cnt_o   = r_err_cnt;

endmodule
